// File: rtl/regfile_access_ctrl_pkg.sv
// regfile_pkg: shared widths, constants and the output FSM encoding for the
// register-memory access controller.
//   ADDR_W       - register address width (16 registers)
//   DATA_W       - register data width
//   TAG_W        - width of the opaque request tag
//   RF_IDLE_DATA - value the register memory returns on a disabled read port
//   out_state_e  - operand output stage: EMPTY / FETCH / HELD
package regfile_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  localparam logic [DATA_W-1:0] RF_IDLE_DATA = 32'h0000FFFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    HELD  = 2'd2
  } out_state_e;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: all bus signals between the filter datapath, the
// access controller and the 16x32 register memory.
//   req_*  - operand fetch request        (datapath -> controller)
//   out_*  - operand return               (controller -> datapath)
//   wb_*   - writeback request            (datapath -> controller)
//   rf_*   - register memory ports        (controller <-> memory)
// Handshakes (req, out, wb): a transfer happens at the posedge where valid and
// ready are both 1. The sender holds valid and its payload stable until that
// edge; ready may depend combinationally on the receiver's state and on the
// payload (req_ready depends on req_src_*), but never on valid.
// modport slave  - the controller
// modport master - the datapath plus register memory (the environment)
interface regfile_access_ctrl_if;
  import regfile_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_src_a;
  logic [ADDR_W-1:0] req_src_b;
  logic              req_use_a;
  logic              req_use_b;
  logic [TAG_W-1:0]  req_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op_a;
  logic [DATA_W-1:0] out_op_b;
  logic [TAG_W-1:0]  out_tag;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hold;

  logic [ADDR_W-1:0] rf_dir_a;
  logic [ADDR_W-1:0] rf_dir_b;
  logic              rf_re_a_n;
  logic              rf_re_b_n;
  logic [DATA_W-1:0] rf_dat_a;
  logic [DATA_W-1:0] rf_dat_b;
  logic [ADDR_W-1:0] rf_dir_wr;
  logic [DATA_W-1:0] rf_di;
  logic              rf_we_n;

  modport slave (
    input  req_valid, req_src_a, req_src_b, req_use_a, req_use_b, req_tag,
    input  out_ready,
    input  wb_valid, wb_addr, wb_data, wb_hold,
    input  rf_dat_a, rf_dat_b,
    output req_ready,
    output out_valid, out_op_a, out_op_b, out_tag,
    output wb_ready,
    output rf_dir_a, rf_dir_b, rf_re_a_n, rf_re_b_n,
    output rf_dir_wr, rf_di, rf_we_n
  );

  modport master (
    output req_valid, req_src_a, req_src_b, req_use_a, req_use_b, req_tag,
    output out_ready,
    output wb_valid, wb_addr, wb_data, wb_hold,
    output rf_dat_a, rf_dat_b,
    input  req_ready,
    input  out_valid, out_op_a, out_op_b, out_tag,
    input  wb_ready,
    input  rf_dir_a, rf_dir_b, rf_re_a_n, rf_re_b_n,
    input  rf_dir_wr, rf_di, rf_we_n
  );

endinterface

// File: rtl/regfile_access_ctrl_wb_queue.sv
// wb_queue: writeback FIFO of {addr,data} feeding the register memory write
// port, plus per-entry address comparison against the two fetch sources.
//   clk, rst_n          - clock, async active-low reset (discards all entries)
//   push_i              - writeback valid; enqueued when ready_o is also 1
//   push_addr_i/data_i  - writeback payload
//   hold_i              - 1 stops the queue from draining
//   cmp_a_i, cmp_b_i    - fetch source addresses to compare
//   ready_o             - room for a writeback this cycle
//   drain_o             - head is being written this cycle, popped at posedge
//   head_addr_o/data_o  - head entry
//   head_oh_o           - one-hot position of the head entry
//   match_a_o/match_b_o - per-entry: entry valid and its address matches
module wb_queue
  import regfile_pkg::*;
#(
  parameter int WQ_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [ADDR_W-1:0]   push_addr_i,
  input  logic [DATA_W-1:0]   push_data_i,
  input  logic                hold_i,
  input  logic [ADDR_W-1:0]   cmp_a_i,
  input  logic [ADDR_W-1:0]   cmp_b_i,
  output logic                ready_o,
  output logic                drain_o,
  output logic [ADDR_W-1:0]   head_addr_o,
  output logic [DATA_W-1:0]   head_data_o,
  output logic [WQ_DEPTH-1:0] head_oh_o,
  output logic [WQ_DEPTH-1:0] match_a_o,
  output logic [WQ_DEPTH-1:0] match_b_o
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WQ_DEPTH);

  logic [ADDR_W-1:0]   addr_q [WQ_DEPTH];
  logic [DATA_W-1:0]   data_q [WQ_DEPTH];
  logic [WQ_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                push;

  assign drain_o = (count_q != '0) && !hold_i;
  // A full queue still accepts when the head leaves in the same cycle.
  assign ready_o = (count_q < DEPTH_C) || drain_o;
  assign push    = push_i && ready_o;

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign head_oh_o   = WQ_DEPTH'(1) << rd_ptr_q;

  always_comb begin
    match_a_o = '0;
    match_b_o = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      match_a_o[i] = valid_q[i] && (addr_q[i] == cmp_a_i);
      match_b_o[i] = valid_q[i] && (addr_q[i] == cmp_b_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WQ_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (drain_o) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      // When full and draining, the push reuses the slot being popped; the
      // later assignment makes the new entry's valid bit win.
      if (push) begin
        addr_q[wr_ptr_q]  <= push_addr_i;
        data_q[wr_ptr_q]  <= push_data_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      case ({push, drain_o})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: client-side controller for the 16x32 register memory.
// Accepts operand fetches and writebacks, drives the memory's two read ports
// and its write port (active-low enables), queues writebacks, stalls fetches
// that would read a register with a pending queued write, and holds returned
// operands in a skid stage under output back-pressure.
//   clk, rst_n  - clock (memory reads on posedge, writes on negedge), async
//                 active-low reset
//   bus         - all handshake and memory signals (slave side)
//   dbg_state_o - current output FSM state
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int WQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_access_ctrl_if.slave bus,
  output out_state_e           dbg_state_o
);

  out_state_e          state_q;
  logic [DATA_W-1:0]   skid_a_q;
  logic [DATA_W-1:0]   skid_b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [ADDR_W-1:0]   dir_a_q;
  logic [ADDR_W-1:0]   dir_b_q;

  logic                drain;
  logic                wb_ready;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic [WQ_DEPTH-1:0] head_oh;
  logic [WQ_DEPTH-1:0] match_a;
  logic [WQ_DEPTH-1:0] match_b;
  logic [WQ_DEPTH-1:0] live_mask;
  logic                hazard;
  logic                req_ready;
  logic                accept;

  wb_queue #(.WQ_DEPTH(WQ_DEPTH)) u_wb_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (bus.wb_valid),
    .push_addr_i (bus.wb_addr),
    .push_data_i (bus.wb_data),
    .hold_i      (bus.wb_hold),
    .cmp_a_i     (bus.req_src_a),
    .cmp_b_i     (bus.req_src_b),
    .ready_o     (wb_ready),
    .drain_o     (drain),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .head_oh_o   (head_oh),
    .match_a_o   (match_a),
    .match_b_o   (match_b)
  );

  // The draining head is written on this cycle's negedge, before the posedge
  // at which the memory samples the read address, so it cannot be stale.
  assign live_mask = drain ? ~head_oh : '1;
  assign hazard    = (bus.req_use_a && |(match_a & live_mask)) ||
                     (bus.req_use_b && |(match_b & live_mask));

  assign req_ready = ((state_q == EMPTY) || bus.out_ready) && !hazard;
  assign accept    = bus.req_valid && req_ready;

  // Read addresses are presented in the accept cycle itself; otherwise they
  // keep the last accepted value.
  assign bus.rf_dir_a  = accept ? bus.req_src_a : dir_a_q;
  assign bus.rf_dir_b  = accept ? bus.req_src_b : dir_b_q;
  assign bus.rf_re_a_n = !(accept && bus.req_use_a);
  assign bus.rf_re_b_n = !(accept && bus.req_use_b);

  assign bus.rf_dir_wr = head_addr;
  assign bus.rf_di     = head_data;
  assign bus.rf_we_n   = !drain;

  assign bus.req_ready = req_ready;
  assign bus.wb_ready  = wb_ready;

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_op_a  = (state_q == FETCH) ? bus.rf_dat_a : skid_a_q;
  assign bus.out_op_b  = (state_q == FETCH) ? bus.rf_dat_b : skid_b_q;
  // No fetch can be accepted while FETCH/HELD waits for out_ready, so tag_q
  // already holds the tag of the operands being held.
  assign bus.out_tag   = tag_q;

  assign dbg_state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      skid_a_q <= '0;
      skid_b_q <= '0;
      tag_q    <= '0;
      dir_a_q  <= '0;
      dir_b_q  <= '0;
    end else begin
      if (accept) begin
        dir_a_q <= bus.req_src_a;
        dir_b_q <= bus.req_src_b;
        tag_q   <= bus.req_tag;
      end
      case (state_q)
        EMPTY: begin
          if (accept) state_q <= FETCH;
        end
        FETCH: begin
          if (bus.out_ready) begin
            state_q <= accept ? FETCH : EMPTY;
          end else begin
            // Memory data is only valid for this one cycle; keep a copy.
            state_q  <= HELD;
            skid_a_q <= bus.rf_dat_a;
            skid_b_q <= bus.rf_dat_b;
          end
        end
        HELD: begin
          if (bus.out_ready) state_q <= accept ? FETCH : EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
